// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared constants, FSM encoding and fetch-fault helper
package imem_responder_pkg;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;
  function automatic logic fetch_fault(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: single-clock word store, one write port and one write-first synchronous read port
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  // write-first so a reload of the word being fetched is seen on the very next read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: wait-stated instruction fetch responder with program-loader port and fault reporting
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] NOP_WORD    = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_mem_read_ready,
  input  logic [31:0] inst_mem_address,
  output logic        inst_mem_is_valid,
  output logic [31:0] inst_mem_read_data,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        access_fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state;
  logic [31:0] addr_q;
  logic [3:0] cnt;
  logic [31:0] rdata;
  logic load_ok, relatch, load_hit;
  logic [AW-1:0] raddr;
  always_comb begin
    load_ok  = load_en && (load_addr < 32'(DEPTH_WORDS));
    relatch  = inst_mem_read_ready && (state == IDLE || inst_mem_address != addr_q);
    load_hit = load_ok && state != IDLE && load_addr[AW-1:0] == addr_q[AW+1:2];
    // read the incoming address on a latch edge so zero wait states still see the right word
    raddr    = relatch ? inst_mem_address[AW+1:2] : addr_q[AW+1:2];
  end
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk(clk),
    .we(load_ok),
    .waddr(load_addr[AW-1:0]),
    .wdata(load_data),
    .raddr(raddr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      addr_q             <= '0;
      cnt                <= '0;
      inst_mem_is_valid  <= 1'b0;
      inst_mem_read_data <= NOP_WORD;
      access_fault       <= 1'b0;
    end else begin
      access_fault <= 1'b0;
      if (state != IDLE && !inst_mem_read_ready) begin
        state              <= IDLE;
        cnt                <= '0;
        inst_mem_is_valid  <= 1'b0;
        inst_mem_read_data <= NOP_WORD;
      end else if (relatch || load_hit) begin
        if (relatch) addr_q <= inst_mem_address;
        state             <= WAIT;
        cnt               <= 4'(WAIT_STATES);
        inst_mem_is_valid <= 1'b0;
      end else if (state == WAIT) begin
        if (cnt == 4'd0) begin
          state              <= VALID;
          inst_mem_is_valid  <= 1'b1;
          inst_mem_read_data <= fetch_fault(addr_q, DEPTH_WORDS) ? NOP_WORD : rdata;
          access_fault       <= fetch_fault(addr_q, DEPTH_WORDS);
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end
endmodule
